// File: rtl/vc_share_arbiter.sv
// ============================================================================
// vc_share_arbiter : round-robin sharing of one CORDIC vectoring engine
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module vc_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int INOUT_WIDTH = 16,
  parameter int ITER_NUM    = 9,
  parameter int ID_W        = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*INOUT_WIDTH-1:0] i_req_x,
  input  logic [NUM_REQ*INOUT_WIDTH-1:0] i_req_y,
  output logic [NUM_REQ-1:0]             o_gnt,
  output logic                           o_vc_valid,
  output logic [INOUT_WIDTH-1:0]         o_vc_x,
  output logic [INOUT_WIDTH-1:0]         o_vc_y,
  input  logic                           i_vc_d_valid,
  input  logic                           i_vc_d,
  input  logic                           i_vc_x_valid,
  input  logic [INOUT_WIDTH-1:0]         i_vc_x,
  output logic                           o_d_valid,
  output logic                           o_d,
  output logic [ID_W-1:0]                o_d_id,
  output logic                           o_x_valid,
  output logic [INOUT_WIDTH-1:0]         o_x,
  output logic [ID_W-1:0]                o_x_id,
  output logic                           o_busy,
  output logic                           o_err
);

  localparam int                 c_cnt_w    = $clog2(ITER_NUM + 2);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ITER_NUM);
  localparam logic [c_cnt_w-1:0] c_cnt_res  = c_cnt_w'(ITER_NUM + 1);
  localparam logic [ID_W-1:0]    c_id_max   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;
  logic [c_cnt_w-1:0]     r_dcnt;
  logic [ID_W-1:0]        r_ptr, r_gnt_id, r_fly_id;
  logic [ID_W-1:0]        w_win, w_cand;
  int                     w_idx;
  logic                   w_any, w_grant_ok, w_grant;
  logic                   r_vc_valid, r_err;
  logic [INOUT_WIDTH-1:0] r_vc_x, r_vc_y;
  logic                   w_d_bad, w_x_bad, w_n_bad;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_win  = '0;
    w_any  = 1'b0;
    w_idx  = 0;
    w_cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_cand = ID_W'(w_idx);
      if (i_req[w_cand]) begin
        w_win = w_cand;
        w_any = 1'b1;
      end
    end
  end

  // Grant at cnt==ITER_NUM lands the next issue on the engine's idle cycle.
  assign w_grant_ok = (r_state == S_IDLE) || ((r_state == S_RUN) && (r_cnt == c_cnt_last));
  assign w_grant    = w_grant_ok && w_any;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_gnt       = '0;
    if (w_grant) o_gnt[w_win] = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_grant) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_cnt_nxt   = c_cnt_w'(1);
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_grant) begin
          w_state_nxt = S_ISSUE;
        end else if (r_cnt >= c_cnt_res) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_gnt_id   <= '0;
      r_fly_id   <= '0;
      r_vc_valid <= 1'b0;
      r_vc_x     <= '0;
      r_vc_y     <= '0;
    end else begin
      r_vc_valid <= w_grant;
      if (w_grant) begin
        r_vc_x   <= i_req_x[w_win*INOUT_WIDTH +: INOUT_WIDTH];
        r_vc_y   <= i_req_y[w_win*INOUT_WIDTH +: INOUT_WIDTH];
        r_gnt_id <= w_win;
        r_ptr    <= (w_win == c_id_max) ? '0 : w_win + 1'b1;
      end
      // Ownership moves only after the previous job's result cycle.
      if (r_state == S_ISSUE) r_fly_id <= r_gnt_id;
    end
  end

  assign w_d_bad = i_vc_d_valid && ((r_cnt == '0) || (r_cnt > c_cnt_last));
  assign w_x_bad = i_vc_x_valid && (r_cnt != c_cnt_res);
  assign w_n_bad = (r_cnt == c_cnt_res) && (r_dcnt != c_cnt_last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) r_dcnt <= '0;
      else if (i_vc_d_valid && (r_dcnt != '1)) r_dcnt <= r_dcnt + 1'b1;
      if (w_d_bad || w_x_bad || w_n_bad) r_err <= 1'b1;
    end
  end

  assign o_vc_valid = r_vc_valid;
  assign o_vc_x     = r_vc_x;
  assign o_vc_y     = r_vc_y;
  assign o_d_valid  = i_vc_d_valid;
  assign o_d        = i_vc_d;
  assign o_d_id     = r_fly_id;
  assign o_x_valid  = i_vc_x_valid;
  assign o_x        = i_vc_x;
  assign o_x_id     = r_fly_id;
  assign o_busy     = (r_state != S_IDLE);
  assign o_err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vc_share_arbiter.sv
// ============================================================================
// tb_vc_share_arbiter : directed bench with a bit-accurate vectoring engine model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_vc_share_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int IT = 9;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_rst;
  logic [NR-1:0]   i_req;
  logic [NR*W-1:0] i_req_x, i_req_y;
  logic [NR-1:0]   o_gnt;
  logic            o_vc_valid;
  logic [W-1:0]    o_vc_x, o_vc_y;
  logic            vc_d_valid, vc_d, vc_x_valid;
  logic [W-1:0]    vc_x;
  logic            o_d_valid, o_d, o_x_valid, o_busy, o_err;
  logic [IDW-1:0]  o_d_id, o_x_id;
  logic [W-1:0]    o_x;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] xs [NR];
  logic [W-1:0] ys [NR];
  logic inject = 1'b0;

  vc_share_arbiter #(.NUM_REQ(NR), .INOUT_WIDTH(W), .ITER_NUM(IT), .ID_W(IDW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_req_x(i_req_x), .i_req_y(i_req_y),
    .o_gnt(o_gnt), .o_vc_valid(o_vc_valid), .o_vc_x(o_vc_x), .o_vc_y(o_vc_y),
    .i_vc_d_valid(vc_d_valid), .i_vc_d(vc_d), .i_vc_x_valid(vc_x_valid), .i_vc_x(vc_x),
    .o_d_valid(o_d_valid), .o_d(o_d), .o_d_id(o_d_id), .o_x_valid(o_x_valid),
    .o_x(o_x), .o_x_id(o_x_id), .o_busy(o_busy), .o_err(o_err)
  );

  // Bit-accurate vectoring model: {d[8:0], x[15:0]}
  function automatic logic [24:0] cordic(input logic [15:0] xi, input logic [15:0] yi);
    logic signed [19:0] x, y, xo;
    logic [8:0] d;
    x = {{4{xi[15]}}, xi};
    y = {{4{yi[15]}}, yi};
    d = '0;
    for (int i = 0; i < IT; i++) begin
      xo = x;
      if (y >= 0) begin
        d[i] = 1'b1;
        x = x + (y >>> i);
        y = y - (xo >>> i);
      end else begin
        x = x - (y >>> i);
        y = y + (xo >>> i);
      end
    end
    return {d, x[15:0]};
  endfunction

  logic [24:0] w_model;
  logic [8:0]  e_d;
  logic [15:0] e_x;
  logic [3:0]  e_cnt;
  assign w_model = cordic(o_vc_x, o_vc_y);

  always @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      e_cnt <= '0; e_d <= '0; e_x <= '0;
      vc_d_valid <= 1'b0; vc_d <= 1'b0; vc_x_valid <= 1'b0; vc_x <= '0;
    end else begin
      vc_d_valid <= 1'b0;
      vc_x_valid <= 1'b0;
      if (o_vc_valid) begin
        e_d <= w_model[24:16];
        e_x <= w_model[15:0];
        vc_d_valid <= 1'b1;
        vc_d <= w_model[16];
        e_cnt <= 4'd1;
      end else if (e_cnt != 4'd0 && e_cnt < 4'd9) begin
        vc_d_valid <= 1'b1;
        vc_d <= e_d[e_cnt];
        e_cnt <= e_cnt + 4'd1;
      end else if (e_cnt == 4'd9) begin
        vc_x_valid <= 1'b1;
        vc_x <= e_x;
        vc_d_valid <= inject;
        e_cnt <= 4'd0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] job_id(input int mode, input int first, input int j);
    case (mode)
      0:       return 2'((first + j) % 4);
      1:       return 2'((j % 2) * 2);
      default: return 2'(first);
    endcase
  endfunction

  // mode 0: all four requesters, each dropped after its grant
  // mode 1: req0/req2 re-asserted right after every grant
  // mode 2: a single job from requester 'first'
  task automatic run_seq(input int mode, input int n, input int first);
    logic [24:0] m;
    logic [1:0]  id;
    int          k;
    bit          e;
    case (mode)
      0:       i_req = 4'b1111;
      1:       i_req = 4'b0101;
      default: i_req = 4'(1) << first;
    endcase
    for (int t = 0; t <= 10*n + 2; t++) begin
      if (t > 0) next_cyc();
      if (t >= 1 && t % 10 == 1 && (t-1)/10 < n) begin
        id = job_id(mode, first, (t-1)/10);
        i_req = i_req & ~(4'(1) << id);
        if (mode == 1 && (t-1)/10 == n-1) i_req = '0;
      end
      if (mode == 1 && t >= 2 && t % 10 == 2 && (t-2)/10 < n-1)
        i_req = i_req | (4'(1) << job_id(mode, first, (t-2)/10));
      #1;
      e  = (t % 10 == 0) && (t/10 < n);
      id = job_id(mode, first, t/10);
      chk("gnt", 32'(o_gnt), e ? (32'(1) << id) : 32'(0));
      e = (t >= 1) && (t % 10 == 1) && ((t-1)/10 < n);
      chk("vc_valid", 32'(o_vc_valid), 32'(e));
      if (e) begin
        id = job_id(mode, first, (t-1)/10);
        chk("vc_x", 32'(o_vc_x), 32'(xs[id]));
        chk("vc_y", 32'(o_vc_y), 32'(ys[id]));
      end
      k = (t >= 1) ? (t-1) % 10 : 0;
      e = (t >= 1) && (k >= 1) && ((t-1)/10 < n);
      chk("d_valid", 32'(o_d_valid), 32'(e));
      if (e) begin
        id = job_id(mode, first, (t-1)/10);
        m  = cordic(xs[id], ys[id]);
        chk("d", 32'(o_d), 32'((m >> (15 + k)) & 25'd1));
        chk("d_id", 32'(o_d_id), 32'(id));
      end
      e = (t >= 11) && ((t-1) % 10 == 0) && ((t-11)/10 < n);
      chk("x_valid", 32'(o_x_valid), 32'(e));
      if (e) begin
        id = job_id(mode, first, (t-11)/10);
        m  = cordic(xs[id], ys[id]);
        chk("x", 32'(o_x), 32'(m[15:0]));
        chk("x_id", 32'(o_x_id), 32'(id));
      end
      chk("busy", 32'(o_busy), 32'((t >= 1) && (t <= 10*n + 1)));
      chk("err", 32'(o_err), 32'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    xs[0] = 16'h8000; ys[0] = 16'h0000;
    xs[1] = 16'h4000; ys[1] = 16'h4000;
    xs[2] = 16'h0000; ys[2] = 16'h7FFF;
    xs[3] = 16'h1234; ys[3] = 16'hFA99;
    for (int i = 0; i < NR; i++) begin
      i_req_x[i*W +: W] = xs[i];
      i_req_y[i*W +: W] = ys[i];
    end
    i_rst = 1'b1;
    i_req = '0;
    repeat (2) next_cyc();
    chk("rst_gnt", 32'(o_gnt), 32'(0));
    chk("rst_vc_valid", 32'(o_vc_valid), 32'(0));
    chk("rst_vc_x", 32'(o_vc_x), 32'(0));
    chk("rst_vc_y", 32'(o_vc_y), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_err", 32'(o_err), 32'(0));
    chk("rst_x_valid", 32'(o_x_valid), 32'(0));
    i_rst = 1'b0;
    repeat (3) next_cyc();

    // Single job from requester 1
    run_seq(2, 1, 1);

    // Reset in the middle of a job from requester 2
    next_cyc();
    i_req = 4'b0100;
    #1;
    chk("mid_gnt", 32'(o_gnt), 32'(4'b0100));
    next_cyc();
    i_req = '0;
    #1;
    chk("mid_vc_valid", 32'(o_vc_valid), 32'(1));
    repeat (4) next_cyc();
    chk("mid_d_valid", 32'(o_d_valid), 32'(1));
    chk("mid_d_id", 32'(o_d_id), 32'(2));
    i_rst = 1'b1;
    next_cyc();
    chk("rr_gnt", 32'(o_gnt), 32'(0));
    chk("rr_vc_valid", 32'(o_vc_valid), 32'(0));
    chk("rr_vc_x", 32'(o_vc_x), 32'(0));
    chk("rr_busy", 32'(o_busy), 32'(0));
    chk("rr_err", 32'(o_err), 32'(0));
    chk("rr_d_valid", 32'(o_d_valid), 32'(0));
    chk("rr_d_id", 32'(o_d_id), 32'(0));
    chk("rr_x_valid", 32'(o_x_valid), 32'(0));
    i_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_cyc();
      chk("rr_no_x", 32'(o_x_valid), 32'(0));
      chk("rr_idle", 32'(o_busy), 32'(0));
    end

    // Pointer restarts at 0: four back-to-back jobs 0,1,2,3
    run_seq(0, 4, 0);
    // Two persistent requesters alternate without starvation
    run_seq(1, 20, 0);

    // Extra d_valid in the result cycle raises a sticky error
    next_cyc();
    inject = 1'b1;
    i_req = 4'b0001;
    #1;
    chk("inj_gnt", 32'(o_gnt), 32'(4'b0001));
    next_cyc();
    i_req = '0;
    repeat (10) next_cyc();
    chk("inj_x_valid", 32'(o_x_valid), 32'(1));
    chk("inj_d_valid", 32'(o_d_valid), 32'(1));
    chk("inj_err_pre", 32'(o_err), 32'(0));
    next_cyc();
    chk("inj_err_set", 32'(o_err), 32'(1));
    repeat (5) next_cyc();
    chk("inj_err_hold", 32'(o_err), 32'(1));
    chk("inj_idle", 32'(o_busy), 32'(0));
    inject = 1'b0;
    i_rst = 1'b1;
    next_cyc();
    chk("inj_err_clr", 32'(o_err), 32'(0));
    i_rst = 1'b0;
    next_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
